// File: rtl/ecm_pkg.sv
// Shared definitions for the ECM scalar broadcaster and the Montgomery ladder
// it feeds: default widths, broadcaster state encoding and the k-stream
// handshake groups.
package ecm_pkg;

  // Default scalar width and matching bit-index width.
  localparam int K_WIDTH_DEF   = 256;
  localparam int IDX_WIDTH_DEF = 8;

  // Broadcaster states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    STREAM = 2'd2
  } bc_state_t;

  // Ladder -> broadcaster: one-cycle request for the next scalar bit.
  typedef struct packed {
    logic req;
  } k_req_t;

  // Broadcaster -> ladder: one-cycle valid carrying the bit and a last flag.
  typedef struct packed {
    logic val;
    logic kbit;
    logic last;
  } k_rsp_t;

  // Bit-index width needed to address a scalar of the given width.
  function automatic int idx_width_for(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ecm_k_broadcaster.sv
// ECM scalar broadcaster: captures K on load, scans downward for the most
// significant set bit, then hands K to the ladder MSB-first, one bit per
// k_req. Flags a zero scalar and signals completion to the controlling FSM.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for load; k_req ignored
// SCAN   | testing k_reg[idx] one bit per cycle, idx counting down
// STREAM | answering requests with k_reg[idx]; done after the last bit
module ecm_k_broadcaster
  import ecm_pkg::*;
#(
  parameter int K_WIDTH   = K_WIDTH_DEF,
  parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [K_WIDTH-1:0]   k_in,
  input  logic                 k_req,
  output logic                 k_val,
  output logic                 k_bit,
  output logic                 k_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err_zero,
  output logic [IDX_WIDTH-1:0] msb_idx
);

  localparam logic [IDX_WIDTH-1:0] IDX_TOP = IDX_WIDTH'(K_WIDTH - 1);

  bc_state_t            state;
  logic [K_WIDTH-1:0]   k_reg;
  logic [IDX_WIDTH-1:0] idx;
  logic                 pend;
  k_rsp_t               rsp;
  k_req_t               req_in;

  logic                 cur_bit;
  logic                 idx_zero;
  logic                 last_sent;
  logic                 want_bit;

  // Scan and stream share the same index counter and bit mux.
  assign cur_bit   = k_reg[idx];
  assign idx_zero  = (idx == '0);
  assign req_in    = '{req: k_req};

  // The k_val carrying k_last is on the outputs this cycle: the run is over.
  assign last_sent = rsp.val & rsp.last;

  // A request held over from SCAN counts the same as a live request.
  assign want_bit  = req_in.req | pend;

  assign k_val  = rsp.val;
  assign k_bit  = rsp.kbit;
  assign k_last = rsp.last;

  // Controller: state, index counter, pending request and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_reg    <= '0;
      idx      <= '0;
      pend     <= 1'b0;
      rsp      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_zero <= 1'b0;
      msb_idx  <= '0;
    end else begin
      rsp      <= '0;
      done     <= 1'b0;
      err_zero <= 1'b0;

      case (state)
        IDLE: begin
          if (load) begin
            k_reg <= k_in;
            idx   <= IDX_TOP;
            pend  <= 1'b0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          // Requests that arrive before the first bit is known are remembered,
          // including one in the same cycle as the move to STREAM.
          if (req_in.req) begin
            pend <= 1'b1;
          end
          if (cur_bit) begin
            msb_idx <= idx;
            state   <= STREAM;
          end else if (idx_zero) begin
            err_zero <= 1'b1;
            busy     <= 1'b0;
            pend     <= 1'b0;
            state    <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        STREAM: begin
          if (last_sent) begin
            // Anything requested alongside the last bit is dropped here.
            done  <= 1'b1;
            busy  <= 1'b0;
            pend  <= 1'b0;
            state <= IDLE;
          end else if (want_bit) begin
            rsp.val  <= 1'b1;
            rsp.kbit <= cur_bit;
            rsp.last <= idx_zero;
            if (!idx_zero) begin
              idx <= idx - 1'b1;
            end
            // A held-over request and a live one in the same cycle are two
            // requests: serve one now and keep the other pending.
            pend <= pend & req_in.req;
          end
        end

        default: begin
          busy  <= 1'b0;
          pend  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecm_k_broadcaster.sv
// Directed bench for ecm_k_broadcaster: scan latency, MSB-first streaming,
// pending requests, zero scalar, ignored loads, load on done, and mid-run reset.
module tb_ecm_k_broadcaster;
  import ecm_pkg::*;

  localparam int KW = 256;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic          k_req = 1'b0;
  logic [KW-1:0] k_in = '0;
  logic          k_val, k_bit, k_last, busy, done, err_zero;
  logic [IW-1:0] msb_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_load = 0;

  int   val_cyc[$];
  logic val_bit[$];
  logic val_last[$];
  int   done_cyc[$];
  int   err_cyc[$];

  ecm_k_broadcaster #(.K_WIDTH(KW), .IDX_WIDTH(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .k_in     (k_in),
    .k_req    (k_req),
    .k_val    (k_val),
    .k_bit    (k_bit),
    .k_last   (k_last),
    .busy     (busy),
    .done     (done),
    .err_zero (err_zero),
    .msb_idx  (msb_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge.
  always @(negedge clk) begin
    if (k_val) begin
      val_cyc.push_back(cyc);
      val_bit.push_back(k_bit);
      val_last.push_back(k_last);
    end
    if (done) done_cyc.push_back(cyc);
    if (err_zero) err_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [KW-1:0] k);
    load = 1'b1;
    k_in = k;
    nxt();
    load = 1'b0;
    t_load = cyc;
  endtask

  task automatic pulse_req();
    k_req = 1'b1;
    nxt();
    k_req = 1'b0;
  endtask

  // Packs n logged bits (or last flags) from index b, first one as MSB.
  function automatic logic [31:0] seq_bits(input int b, input int n, input bit want_last);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = r << 1;
      if (b + i < val_bit.size()) r[0] = want_last ? val_last[b + i] : val_bit[b + i];
    end
    return r;
  endfunction

  initial begin
    int b0, d0, e0, lat, nmis;
    logic [KW-1:0] kk;

    // Reset state
    rst_n = 1'b0;
    nxt();
    chk("rst_outs", {26'd0, k_val, k_bit, k_last, busy, done, err_zero}, 0);
    chk("rst_msb", msb_idx, 0);
    rst_n = 1'b1;
    nxt();

    // K=5, requests after the scan
    b0 = val_cyc.size(); d0 = done_cyc.size(); e0 = err_cyc.size();
    do_load(KW'(5));
    chk("t1_busy", busy, 1);
    lat = 0;
    while (msb_idx != 8'd2 && lat < 400) begin nxt(); lat++; end
    chk("t1_scan_lat", lat, 254);
    chk("t1_msb", msb_idx, 2);
    for (int r = 0; r < 3; r++) begin
      repeat (10) nxt();
      pulse_req();
    end
    repeat (3) nxt();
    chk("t1_nval", val_cyc.size() - b0, 3);
    chk("t1_bits", seq_bits(b0, 3, 1'b0), 32'b101);
    chk("t1_lasts", seq_bits(b0, 3, 1'b1), 32'b001);
    chk("t1_ndone", done_cyc.size() - d0, 1);
    if (done_cyc.size() > d0 && val_cyc.size() >= b0 + 3)
      chk("t1_done_lat", done_cyc[d0] - val_cyc[b0 + 2], 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_nerr", err_cyc.size() - e0, 0);

    // K=1: full-length scan, single bit
    b0 = val_cyc.size(); d0 = done_cyc.size();
    do_load(KW'(1));
    lat = 0;
    while (msb_idx != 8'd0 && lat < 400) begin nxt(); lat++; end
    chk("t2_scan_lat", lat, 256);
    pulse_req();
    repeat (3) nxt();
    chk("t2_nval", val_cyc.size() - b0, 1);
    chk("t2_bit_last", seq_bits(b0, 1, 1'b0) * 2 + seq_bits(b0, 1, 1'b1), 3);
    chk("t2_ndone", done_cyc.size() - d0, 1);

    // K=0: zero-scalar error, stray requests produce nothing
    b0 = val_cyc.size(); d0 = done_cyc.size(); e0 = err_cyc.size();
    do_load(KW'(0));
    repeat (20) nxt();
    pulse_req();
    lat = 0;
    while (err_cyc.size() == e0 && lat < 400) begin nxt(); lat++; end
    chk("t3_err_seen", err_cyc.size() - e0, 1);
    if (err_cyc.size() > e0) chk("t3_err_lat", err_cyc[e0] - t_load, 256);
    chk("t3_err_busy", {30'd0, err_zero, busy}, 2);
    pulse_req();
    pulse_req();
    repeat (5) nxt();
    chk("t3_nval", val_cyc.size() - b0, 0);
    chk("t3_ndone", done_cyc.size() - d0, 0);
    chk("t3_nerr", err_cyc.size() - e0, 1);

    // K=2^255 with k_req held high for 256 cycles
    b0 = val_cyc.size(); d0 = done_cyc.size();
    kk = '0;
    kk[KW-1] = 1'b1;
    do_load(kk);
    k_req = 1'b1;
    repeat (256) nxt();
    k_req = 1'b0;
    repeat (4) nxt();
    chk("t4_msb", msb_idx, 255);
    chk("t4_nval", val_cyc.size() - b0, 256);
    if (val_cyc.size() > b0) chk("t4_first_lat", val_cyc[b0] - t_load, 2);
    nmis = 0;
    for (int i = 0; i < 256; i++) begin
      if (b0 + i < val_bit.size()) begin
        if (val_bit[b0 + i] !== (i == 0)) nmis++;
        if (val_last[b0 + i] !== (i == 255)) nmis++;
        if (val_cyc[b0 + i] - t_load != i + 2) nmis++;
      end
    end
    chk("t4_stream", nmis, 0);
    chk("t4_ndone", done_cyc.size() - d0, 1);
    if (done_cyc.size() > d0) chk("t4_done_lat", done_cyc[d0] - t_load, 258);
    pulse_req();
    pulse_req();
    pulse_req();
    repeat (3) nxt();
    chk("t4_extra", val_cyc.size() - b0, 256);

    // K=5 with a request during SCAN, then load coincident with done
    b0 = val_cyc.size(); d0 = done_cyc.size();
    do_load(KW'(5));
    repeat (5) nxt();
    pulse_req();
    lat = 0;
    while (val_cyc.size() == b0 && lat < 400) begin nxt(); lat++; end
    if (val_cyc.size() > b0) chk("t5_pend_lat", val_cyc[b0] - t_load, 255);
    chk("t5_first", seq_bits(b0, 1, 1'b0) * 2 + seq_bits(b0, 1, 1'b1), 2);
    repeat (3) nxt();
    pulse_req();
    repeat (3) nxt();
    pulse_req();
    nxt();
    chk("t5_done_now", done, 1);
    kk = '0;
    kk[KW-1] = 1'b1;
    do_load(kk);
    nxt();
    chk("t5_reload_msb", msb_idx, 255);
    chk("t5_reload_busy", busy, 1);
    chk("t5_nval", val_cyc.size() - b0, 3);
    chk("t5_bits", seq_bits(b0, 3, 1'b0), 32'b101);
    chk("t5_lasts", seq_bits(b0, 3, 1'b1), 32'b001);
    chk("t5_ndone", done_cyc.size() - d0, 1);

    // K=5, ignored load mid-STREAM, then reset mid-run
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();
    b0 = val_cyc.size(); d0 = done_cyc.size();
    do_load(KW'(5));
    repeat (260) nxt();
    pulse_req();
    repeat (2) nxt();
    load = 1'b1;
    k_in = '1;
    nxt();
    load = 1'b0;
    repeat (2) nxt();
    chk("t6_msb_kept", msb_idx, 2);
    chk("t6_busy_kept", busy, 1);
    pulse_req();
    nxt();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {26'd0, k_val, k_bit, k_last, busy, done, err_zero}, 0);
    chk("t6_rst_msb", msb_idx, 0);
    nxt();
    rst_n = 1'b1;
    nxt();
    pulse_req();
    repeat (3) nxt();
    pulse_req();
    repeat (5) nxt();
    chk("t6_nval", val_cyc.size() - b0, 2);
    chk("t6_bits", seq_bits(b0, 2, 1'b0), 32'b10);
    chk("t6_ndone", done_cyc.size() - d0, 0);
    chk("t6_busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
